upacc_sequencer: RTL and testbench

CPU-side access sequencer for a group of shared engine/CPU memory wrappers. It accepts one processor read or write at a time and decodes the bank from the upper address bits. It then drives that bank's CPU port (upen/upa/upws/uprs/updi), waits for the bank's ready, returns read data, and acknowledges. A timeout guarantees the processor bus never hangs on a bank that is inactive or permanently starved by engine traffic.

---
 rtl/upacc_sequencer_pkg.sv | 15 +
 rtl/upacc_sequencer_if.sv | 38 +++
 rtl/upacc_bankmux.sv | 29 ++
 rtl/upacc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_upacc_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/upacc_sequencer_pkg.sv
// upacc_sequencer_pkg
//   Shared definitions for the CPU access sequencer: FSM state encoding and
//   the default timeout budget (cycles waited for a bank's uprdy).
package upacc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } upacc_state_t;

  localparam int UPACC_TOUT_DEFAULT = 200;

endpackage

// File: rtl/upacc_sequencer_if.sv
// upacc_sequencer_if
//   Bundles the processor request/ack handshake and the shared bank-side CPU
//   port of the memory wrappers.
//   slave  : the sequencer (consumes cpu_req/fields, drives ack and bank port)
//   master : the processor + bank models (drive requests, uprdy, updo_bus)
//   Signals: cpu_req/rnw/addr/wdat -> request; cpu_ack/rdat/err <- response;
//            upen/upa/upws/uprs/updi -> banks; updo_bus/uprdy <- banks.
interface upacc_sequencer_if #(
  parameter int NBANK   = 4,
  parameter int BANKBIT = 2,
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32
);
  logic                       cpu_req;
  logic                       cpu_rnw;
  logic [BANKBIT+ADDRBIT-1:0] cpu_addr;
  logic [WIDTH-1:0]           cpu_wdat;
  logic                       cpu_ack;
  logic [WIDTH-1:0]           cpu_rdat;
  logic                       cpu_err;
  logic [NBANK-1:0]           upen;
  logic [ADDRBIT-1:0]         upa;
  logic                       upws;
  logic                       uprs;
  logic [WIDTH-1:0]           updi;
  logic [NBANK*WIDTH-1:0]     updo_bus;
  logic [NBANK-1:0]           uprdy;

  modport slave (
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wdat, updo_bus, uprdy,
    output cpu_ack, cpu_rdat, cpu_err, upen, upa, upws, uprs, updi
  );

  modport master (
    output cpu_req, cpu_rnw, cpu_addr, cpu_wdat, updo_bus, uprdy,
    input  cpu_ack, cpu_rdat, cpu_err, upen, upa, upws, uprs, updi
  );
endinterface

// File: rtl/upacc_bankmux.sv
// upacc_bankmux
//   Combinational selector of one bank's ready and read data by bank index.
//   An index >= NBANK selects nothing (rdy=0, rdat=0).
//   Ports: bank (index), uprdy (per-bank ready), updo_bus (packed per-bank
//          data, bank k at [k*WIDTH +: WIDTH]), rdy / rdat (selected).
module upacc_bankmux #(
  parameter int NBANK   = 4,
  parameter int BANKBIT = 2,
  parameter int WIDTH   = 32
) (
  input  logic [BANKBIT-1:0]     bank,
  input  logic [NBANK-1:0]       uprdy,
  input  logic [NBANK*WIDTH-1:0] updo_bus,
  output logic                   rdy,
  output logic [WIDTH-1:0]       rdat
);

  always_comb begin
    rdy  = 1'b0;
    rdat = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (bank == BANKBIT'(k)) begin
        rdy  = uprdy[k];
        rdat = updo_bus[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/upacc_sequencer.sv
// upacc_sequencer
//   Serialises one processor read/write at a time onto the CPU port of the
//   addressed memory bank, waits for that bank's uprdy (bounded by TOUT
//   cycles) and returns a one-cycle cpu_ack with rdat/err.
//   Ports: clk, rstn (async active-low), bus (upacc_sequencer_if.slave).
//   All outputs are registered; each register is loaded with the value that
//   belongs to the state being entered.
//
//   state | meaning
//   IDLE  | wait for cpu_req, latch request, decode bank
//   ISSUE | one-cycle read/write strobe to the selected bank
//   WAIT  | hold upen, wait for uprdy[bank] or timeout
//   DONE  | upen dropped, cpu_ack pulse with rdat/err
module upacc_sequencer
  import upacc_sequencer_pkg::*;
#(
  parameter int NBANK   = 4,
  parameter int BANKBIT = 2,
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32,
  parameter int TOUTBIT = 8,
  parameter int TOUT    = UPACC_TOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  upacc_sequencer_if.slave  bus
);

  localparam int AW = BANKBIT + ADDRBIT;

  upacc_state_t state_q, state_d;

  logic               rnw_q;
  logic [BANKBIT-1:0] bank_q;
  logic               lat_ld;
  logic [TOUTBIT-1:0] cnt_q, cnt_d;

  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   rdat_q, rdat_d;
  logic [NBANK-1:0]   upen_q, upen_d;
  logic               upws_q, upws_d;
  logic               uprs_q, uprs_d;
  logic [ADDRBIT-1:0] upa_q, upa_d;
  logic [WIDTH-1:0]   updi_q, updi_d;

  logic               rdy_sel;
  logic [WIDTH-1:0]   dat_sel;
  logic [BANKBIT-1:0] req_bank;

  assign req_bank = bus.cpu_addr[AW-1 -: BANKBIT];

  upacc_bankmux #(
    .NBANK   (NBANK),
    .BANKBIT (BANKBIT),
    .WIDTH   (WIDTH)
  ) u_bankmux (
    .bank     (bank_q),
    .uprdy    (bus.uprdy),
    .updo_bus (bus.updo_bus),
    .rdy      (rdy_sel),
    .rdat     (dat_sel)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      rnw_q   <= 1'b0;
      bank_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      upen_q  <= '0;
      upws_q  <= 1'b0;
      uprs_q  <= 1'b0;
      upa_q   <= '0;
      updi_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      upen_q  <= upen_d;
      upws_q  <= upws_d;
      uprs_q  <= uprs_d;
      upa_q   <= upa_d;
      updi_q  <= updi_d;
      if (lat_ld) begin
        rnw_q  <= bus.cpu_rnw;
        bank_q <= req_bank;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_ld  = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = '0;
    upen_d  = upen_q;
    upws_d  = 1'b0;
    uprs_d  = 1'b0;
    upa_d   = upa_q;
    updi_d  = updi_q;
    case (state_q)
      ST_IDLE: begin
        upen_d = '0;
        upa_d  = '0;
        updi_d = '0;
        if (bus.cpu_req) begin
          lat_ld = 1'b1;
          if (int'(req_bank) >= NBANK) begin
            // Unpopulated bank: answer with an error without touching any bank.
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            upen_d  = NBANK'(1) << req_bank;
            upa_d   = bus.cpu_addr[ADDRBIT-1:0];
            updi_d  = bus.cpu_wdat;
            upws_d  = !bus.cpu_rnw;
            uprs_d  = bus.cpu_rnw;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ready is checked before the timeout so a coincident uprdy wins.
        if (rdy_sel || cnt_q == TOUTBIT'(TOUT - 1)) begin
          ack_d   = 1'b1;
          err_d   = !rdy_sel;
          rdat_d  = (rdy_sel && rnw_q) ? dat_sel : '0;
          upen_d  = '0;
          upa_d   = '0;
          updi_d  = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + TOUTBIT'(1);
        end
      end
      ST_DONE: begin
        upen_d  = '0;
        upa_d   = '0;
        updi_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cpu_ack  = ack_q;
  assign bus.cpu_err  = err_q;
  assign bus.cpu_rdat = rdat_q;
  assign bus.upen     = upen_q;
  assign bus.upws     = upws_q;
  assign bus.uprs     = uprs_q;
  assign bus.upa      = upa_q;
  assign bus.updi     = updi_q;

endmodule

// File: tb/tb_upacc_sequencer.sv
// tb_upacc_sequencer
//   Directed bench for upacc_sequencer with NBANK=3 and TOUT=16. Each request
//   pushes its expected response (ack cycle, rdat, err) into a scoreboard
//   queue; an independent monitor pops and compares on every cpu_ack.
//   Cycle n of a request is the n-th clock after the cycle in which cpu_req
//   is first presented (cycle 0).
module tb_upacc_sequencer;

  localparam int NBANK   = 3;
  localparam int BANKBIT = 2;
  localparam int ADDRBIT = 5;
  localparam int WIDTH   = 32;
  localparam int TOUTBIT = 8;
  localparam int TOUT    = 16;

  typedef struct {
    logic [31:0] rdat;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  upacc_sequencer_if #(
    .NBANK(NBANK), .BANKBIT(BANKBIT), .ADDRBIT(ADDRBIT), .WIDTH(WIDTH)
  ) bus ();

  upacc_sequencer #(
    .NBANK(NBANK), .BANKBIT(BANKBIT), .ADDRBIT(ADDRBIT), .WIDTH(WIDTH),
    .TOUTBIT(TOUTBIT), .TOUT(TOUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rstn && bus.cpu_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("ack_rdat", 64'(bus.cpu_rdat), 64'(e.rdat));
        chk("ack_err", 64'(bus.cpu_err), 64'(e.err));
      end
    end
  end

  function automatic logic [NBANK*WIDTH-1:0] bank_data(input logic [1:0] bank,
                                                       input logic [31:0] mdat);
    logic [NBANK*WIDTH-1:0] v;
    for (int k = 0; k < NBANK; k++)
      v[k*WIDTH +: WIDTH] = (int'(bank) == k) ? mdat : (32'h0BAD_0000 | 32'(k));
    return v;
  endfunction

  // Issue one request at the current negedge (cycle 0) and model the banks.
  // rdy_cyc / oth_cyc: cycle in which uprdy of own / other bank pulses (0 = never).
  task automatic do_req(input string nm, input logic rnw, input logic [1:0] bank,
                        input logic [4:0] word, input logic [31:0] wdat,
                        input logic [31:0] mdat, input int rdy_cyc,
                        input int oth_cyc, input logic [1:0] oth_bank,
                        input int exp_ack, input logic exp_err,
                        input logic [31:0] exp_rdat, input logic [2:0] exp_upen);
    int   c0;
    int   ws_n;
    int   rs_n;
    int   bad_upen;
    exp_t e;
    logic [2:0] exp_now;
    ws_n     = 0;
    rs_n     = 0;
    bad_upen = 0;
    c0       = cyc;
    bus.cpu_req  = 1'b1;
    bus.cpu_rnw  = rnw;
    bus.cpu_addr = {bank, word};
    bus.cpu_wdat = wdat;
    bus.updo_bus = bank_data(bank, mdat);
    e.rdat = exp_rdat;
    e.err  = exp_err;
    e.cyc  = c0 + exp_ack;
    sb.push_back(e);
    for (int n = 1; n <= exp_ack + 1; n++) begin
      @(negedge clk);
      bus.uprdy = '0;
      if (n == rdy_cyc && int'(bank) < NBANK) bus.uprdy[bank] = 1'b1;
      if (n == oth_cyc) bus.uprdy[oth_bank] = 1'b1;
      if (bus.upws === 1'b1) ws_n++;
      if (bus.uprs === 1'b1) rs_n++;
      if (n == 1 && exp_upen != 3'b000) begin
        chk({nm, "_issue_upws"}, 64'(bus.upws), 64'(!rnw));
        chk({nm, "_issue_uprs"}, 64'(bus.uprs), 64'(rnw));
        chk({nm, "_issue_upa"}, 64'(bus.upa), 64'(word));
        chk({nm, "_issue_updi"}, 64'(bus.updi), 64'(wdat));
      end
      exp_now = (n < exp_ack) ? exp_upen : 3'b000;
      if (bus.upen !== exp_now) bad_upen++;
      if (n == exp_ack) begin
        chk({nm, "_upen_done"}, 64'(bus.upen), 64'd0);
        bus.cpu_req = 1'b0;
      end
    end
    bus.uprdy = '0;
    bus.cpu_req = 1'b0;
    chk({nm, "_upen_cycles_wrong"}, 64'(bad_upen), 64'd0);
    chk({nm, "_upws_count"}, 64'(ws_n), 64'((exp_upen != 3'b000 && !rnw) ? 1 : 0));
    chk({nm, "_uprs_count"}, 64'(rs_n), 64'((exp_upen != 3'b000 && rnw) ? 1 : 0));
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_ack: got %0d pending responses expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"}, 64'(bus.cpu_ack), 64'd0);
    chk({nm, "_err"}, 64'(bus.cpu_err), 64'd0);
    chk({nm, "_rdat"}, 64'(bus.cpu_rdat), 64'd0);
    chk({nm, "_upen"}, 64'(bus.upen), 64'd0);
    chk({nm, "_strobes"}, 64'({bus.upws, bus.uprs}), 64'd0);
    chk({nm, "_upa"}, 64'(bus.upa), 64'd0);
    chk({nm, "_updi"}, 64'(bus.updi), 64'd0);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rstn         = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdat = '0;
    bus.updo_bus = '0;
    bus.uprdy    = '0;
    #3;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    //     name      rnw   bank  word  wdat          mdat          rdy oth ob    ack err  rdat          upen
    do_req("write",  1'b0, 2'd1, 5'd3, 32'hA5A5_0001, 32'h1111_1111, 8, 0, 2'd0, 9, 1'b0, 32'h0,         3'b010);
    do_req("read",   1'b1, 2'd2, 5'd7, 32'h0,         32'hDEAD_BEEF, 8, 0, 2'd0, 9, 1'b0, 32'hDEAD_BEEF, 3'b100);
    do_req("tout",   1'b1, 2'd0, 5'd1, 32'h0,         32'h2222_2222, 0, 0, 2'd0, 18, 1'b1, 32'h0,        3'b001);
    do_req("badbank",1'b1, 2'd3, 5'd4, 32'h0,         32'h3333_3333, 0, 0, 2'd0, 1, 1'b1, 32'h0,         3'b000);
    do_req("coinc",  1'b1, 2'd1, 5'd30,32'h0,         32'h1234_5678, 17, 0, 2'd0, 18, 1'b0, 32'h1234_5678, 3'b010);
    do_req("othrd",  1'b1, 2'd0, 5'd2, 32'h0,         32'hCAFE_0000, 10, 4, 2'd2, 11, 1'b0, 32'hCAFE_0000, 3'b001);
    do_req("othto",  1'b0, 2'd2, 5'd5, 32'h5A5A_5A5A, 32'h0,         0, 5, 2'd0, 18, 1'b1, 32'h0,         3'b100);

    // Reset pulsed while waiting on bank 1: outputs clear, no ack follows.
    bus.cpu_req  = 1'b1;
    bus.cpu_rnw  = 1'b1;
    bus.cpu_addr = {2'd1, 5'd6};
    bus.cpu_wdat = 32'h0;
    bus.updo_bus = bank_data(2'd1, 32'h7777_7777);
    repeat (4) @(negedge clk);
    chk("rst_wait_upen", 64'(bus.upen), 64'b010);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (25) @(negedge clk);
    chk_all_zero("rst_after");

    do_req("postrst",1'b1, 2'd1, 5'd9, 32'h0,         32'h0BAD_F00D, 3, 0, 2'd0, 4, 1'b0, 32'h0BAD_F00D, 3'b010);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
